// File: rtl/fixed_float_converter.sv
// Sign-magnitude fixed-point (1.INT_W.FRAC_W) to IEEE-754 single converter with enable/done handshake.
// Define FIXED_FLOAT_FAST_NORM_EN to normalise in one cycle instead of one bit per cycle.
module fixed_float_converter #(
  parameter int INT_W  = 1,
  parameter int FRAC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [INT_W+FRAC_W:0]   data,
  output logic [31:0]             result,
  output logic                    done,
  output logic                    busy
);

  localparam int MW = INT_W + FRAC_W;

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  state_t          state_q;
  logic            sign_q;
  logic            zero_q;
  logic [MW-1:0]   mag_q;
  logic [4:0]      shift_q;
  logic [31:0]     result_q;
  logic            done_q;
  logic            busy_q;

  logic [7:0]      exp_d;
  logic [22:0]     mant_d;

  // The leading one is implicit; the remaining magnitude bits are left-aligned into the mantissa.
  always_comb begin
    exp_d  = 8'(127 + INT_W - 1) - {3'b000, shift_q};
    mant_d = 23'(mag_q[MW-2:0]) << (24 - MW);
  end

`ifdef FIXED_FLOAT_FAST_NORM_EN
  logic [4:0] lz_d;
  logic       lz_found;

  always_comb begin
    lz_d     = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (!lz_found && mag_q[MW-1-i]) begin
        lz_d     = 5'(i);
        lz_found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      mag_q    <= '0;
      shift_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            sign_q  <= data[MW];
            mag_q   <= data[MW-1:0];
            shift_q <= '0;
            zero_q  <= (data[MW-1:0] == '0);
            busy_q  <= 1'b1;
            state_q <= (data[MW-1:0] == '0) ? PACK : NORM;
          end
        end
        NORM: begin
`ifdef FIXED_FLOAT_FAST_NORM_EN
          mag_q   <= mag_q << lz_d;
          shift_q <= lz_d;
          state_q <= PACK;
`else
          if (mag_q[MW-1]) begin
            state_q <= PACK;
          end else begin
            mag_q   <= mag_q << 1;
            shift_q <= shift_q + 5'd1;
          end
`endif
        end
        PACK: begin
          result_q <= zero_q ? '0 : {sign_q, exp_d, mant_d};
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fixed_float_converter.sv
// Self-checking bench for fixed_float_converter: directed plan vectors, random operands, busy/back-to-back/reset scenarios.
module tb_fixed_float_converter;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [21:0] data;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int n_cmp;
  int n_bad;

`ifdef FIXED_FLOAT_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  fixed_float_converter #(.INT_W(1), .FRAC_W(20)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .data   (data),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = +/- mag / 2^20, encoded through the double-precision bits and narrowed.
  function automatic logic [31:0] ref_float(input logic [21:0] d);
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    if (d[20:0] == '0) return 32'h0000_0000;
    r = real'(int'(d[20:0])) / 1048576.0;
    if (d[21]) r = -r;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic int ref_lat(input logic [21:0] d);
    int v;
    int lz;
    v = int'(d[20:0]);
    if (v == 0) return 1;
    if (FAST) return 2;
    lz = 0;
    while (v < 1048576) begin
      v  = v * 2;
      lz = lz + 1;
    end
    return lz + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after a capture edge; returns latency in edges, or -1 on timeout.
  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy_mid edge=%0d got=%b want=1", name, k, busy);
      end
    end
    n_cmp++;
    if (lat < 0) begin
      n_bad++;
      $display("FAIL %s timeout got=no_done want=done within 40 edges", name);
    end
  endtask

  task automatic check_result(input string name, input logic [21:0] d, input int lat);
    logic [31:0] exp_r;
    int          exp_l;
    exp_r = ref_float(d);
    exp_l = ref_lat(d);
    n_cmp++;
    if (lat !== exp_l) begin
      n_bad++;
      $display("FAIL %s latency data=%h got=%0d want=%0d", name, d, lat, exp_l);
    end
    n_cmp++;
    if (result !== exp_r) begin
      n_bad++;
      $display("FAIL %s result data=%h got=%h want=%h", name, d, result, exp_r);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done got=%b want=0", name, busy);
    end
  endtask

  task automatic run_conv(input string name, input logic [21:0] d);
    int          lat;
    logic [31:0] held;
    enable = 1'b1;
    data   = d;
    tick();
    enable = 1'b0;
    data   = 22'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_after_capture got=%b want=1", name, busy);
    end
    wait_done(name, lat);
    if (lat > 0) begin
      check_result(name, d, lat);
      held = result;
      tick();
      n_cmp++;
      if (done !== 1'b0 || result !== held) begin
        n_bad++;
        $display("FAIL %s pulse_hold done=%b result=%h want done=0 result=%h", name, done, result, held);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    data   = '0;
    #12;
    n_cmp++;
    if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state result=%h done=%b busy=%b want 0/0/0", result, done, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_directed();
    logic [21:0] vec [7];
    vec[0] = 22'h100000;
    vec[1] = 22'h380000;
    vec[2] = 22'h1FFFFF;
    vec[3] = 22'h080000;
    vec[4] = 22'h000001;
    vec[5] = 22'h000000;
    vec[6] = 22'h200000;
    for (int i = 0; i < 7; i++) run_conv($sformatf("directed%0d", i), vec[i]);
  endtask

  task automatic test_random();
    logic [21:0] d;
    for (int i = 0; i < 40; i++) begin
      d = 22'($urandom);
      d[20:0] = d[20:0] >> $urandom_range(0, 21);
      run_conv($sformatf("random%0d", i), d);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    int p;
    p = FAST ? 1 : 5;
    enable = 1'b1;
    data   = 22'h000001;
    tick();
    enable = 1'b0;
    repeat (p - 1) tick();
    enable = 1'b1;
    data   = 22'h100000;
    tick();
    enable = 1'b0;
    wait_done("ignore_busy", lat);
    if (lat > 0) begin
      check_result("ignore_busy", 22'h000001, lat + p);
      for (int k = 0; k < 4; k++) begin
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL ignore_busy_no_second done=%b busy=%b want 0/0", done, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    enable = 1'b1;
    data   = 22'h000001;
    tick();
    data = 22'h100000;
    wait_done("b2b_first", lat);
    if (lat > 0) begin
      check_result("b2b_first", 22'h000001, lat);
      tick();
      enable = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_second_capture busy=%b want=1", busy);
      end
      wait_done("b2b_second", lat);
      if (lat > 0) check_result("b2b_second", 22'h100000, lat);
    end
    tick();
  endtask

  task automatic test_midreset();
    enable = 1'b1;
    data   = 22'h000001;
    tick();
    enable = 1'b0;
    if (!FAST) repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_async result=%h done=%b busy=%b want 0/0/0", result, done, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset_no_done edge=%0d done=%b busy=%b want 0/0", k, done, busy);
      end
    end
    run_conv("after_reset", 22'h0C0000);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_float_converter.md
Name: fixed_float_converter

Overview:
- Multi-cycle converter from the 22-bit sign-magnitude fixed-point format to IEEE-754 single precision.
- Fixed format: 1 sign bit, 1 integer bit, 20 fractional bits.
- Sits directly downstream of the float-to-fixed conversion stage. Converts fixed-point datapath results back to float for the float arithmetic units.
- Normalises iteratively (one left shift per cycle) with an enable/done handshake; a single-cycle normaliser is available as a compile option.

Parameters:
- INT_W, 1: integer bits of the fixed magnitude.
- FRAC_W, 20: fractional bits of the fixed magnitude. Fixed width = 1+INT_W+FRAC_W. INT_W+FRAC_W <= 24, so the conversion is always exact.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start request; sampled only while idle.
- data  input  22  fixed operand {sign, magnitude[20:0]}; magnitude value = mag / 2^FRAC_W.
- result  output  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}.
- done  output  1  one-cycle pulse; result valid from this cycle.
- busy  output  1  high from the capture edge until the edge that asserts done.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, result=0, done=0, busy=0, internal magnitude/shift counter cleared. Reset mid-conversion abandons the operation; no done pulse follows.
- States: IDLE, NORM, PACK.
- IDLE:
  - On a rising edge with enable=1, capture sign and magnitude and set busy=1.
  - If magnitude==0, go to PACK with the zero flag set; otherwise go to NORM.
  - enable=0 keeps IDLE.
- NORM:
  - If mag[INT_W+FRAC_W-1]==1, go to PACK.
  - Otherwise mag <= mag<<1 and shift_cnt <= shift_cnt+1; stay in NORM.
  - shift_cnt is 5 bits, maximum 20.
- PACK:
  - Zero flag set: result <= 32'h0000_0000 (negative zero also yields +0).
  - Otherwise: exponent = 127 + (INT_W-1) - shift_cnt, which is 127-shift_cnt at defaults, range 107..127.
  - Mantissa = mag[FRAC_W+INT_W-2:0] left-aligned into mant[22:0], zero-filled below. At defaults: mant[22:3]=mag[19:0], mant[2:0]=0.
  - Sign copied from the captured sign.
  - done <= 1 for exactly one cycle, busy <= 0, go to IDLE.
- Latency L = rising edges after the capture edge up to and including the edge that raises done:
  - non-zero operand: L = s+2, where s = leading zeros of the magnitude (0..20), so L = 2..22;
  - zero operand: L = 1.
- enable while busy=1 is ignored; the operand is not queued.
- enable=1 in the cycle done is high is accepted, since the state is IDLE at that edge. A new conversion can therefore start back-to-back.
- result holds its value between conversions and changes only in PACK.
- data is sampled only at the capture edge; later changes have no effect.
- No overflow or underflow is possible; the denormal/inf/NaN encodings are never produced.

Optional Feature:
- Macro FIXED_FLOAT_FAST_NORM_EN.
- Defined: NORM uses a combinational leading-one detector and shifts by the full amount in one cycle, then goes to PACK. Non-zero latency is fixed at L=2; zero latency stays L=1. Results are identical.
- Undefined: iterative one-bit-per-cycle normalisation as described above.

Test Plan:
- data=22'h100000 (+1.0) -> result=32'h3F80_0000, done after L=2, busy high between capture and done.
- data=22'h380000 (-1.5) -> 32'hBFC0_0000, L=2; data=22'h1FFFFF (max) -> 32'h3FFF_FFF8, L=2.
- data=22'h080000 (+0.5) -> 32'h3F00_0000, L=3; data=22'h000001 (2^-20) -> 32'h3580_0000, L=22 (L=2 with FIXED_FLOAT_FAST_NORM_EN).
- data=22'h000000 and 22'h200000 (-0) -> 32'h0000_0000, L=1.
- Start 22'h000001, pulse enable with 22'h100000 at busy cycle 5 -> ignored, result=32'h3580_0000. Then enable held through done -> next conversion starts with no gap, giving 32'h3F80_0000 two edges later.
- Assert rst_n=0 during NORM of 22'h000001 -> result=0, done=0, busy=0 immediately. No done pulse after release until a new enable.
